// File: rtl/wb_byte_master_if.sv
// Byte-stream command channel plus Wishbone classic single-word bus, grouped
// so the bridge and its environment share one bundle.
interface wb_byte_master_if;
  logic [7:0]  rx_dat_i;
  logic        rx_stb_i;
  logic        rx_ack_o;
  logic [7:0]  tx_dat_o;
  logic        tx_stb_o;
  logic        tx_ack_i;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [29:0] adr_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        ack_i;

  modport master (
    input  rx_dat_i, rx_stb_i, tx_ack_i, dat_i, ack_i,
    output rx_ack_o, tx_dat_o, tx_stb_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
  );

  modport slave (
    output rx_dat_i, rx_stb_i, tx_ack_i, dat_i, ack_i,
    input  rx_ack_o, tx_dat_o, tx_stb_o, cyc_o, stb_o, we_o, adr_o, sel_o, dat_o
  );
endinterface

// File: rtl/wb_byte_master.sv
// Byte-stream to Wishbone classic bridge: parses W/R command frames, runs one
// 32-bit single cycle per frame and streams back a status byte (+ read data).
module wb_byte_master #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [7:0]  CMD_WRITE = 8'h57,
  parameter logic [7:0]  CMD_READ  = 8'h52
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_byte_master_if.master  bus
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, TX_STATUS, TX_DATA} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  ST_OK    = 8'h00;
  localparam logic [7:0]  ST_TMO   = 8'hEE;

  state_t      state;
  logic        is_wr;
  logic [1:0]  bcnt;
  logic [23:0] addr_q;
  logic [31:0] rdata;
  logic [7:0]  status;
  logic [15:0] tmo;
  logic        rx_fire;
  logic        tx_fire;

  assign rx_fire = bus.rx_stb_i & bus.rx_ack_o;
  assign tx_fire = bus.tx_stb_o & bus.tx_ack_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      is_wr        <= 1'b0;
      bcnt         <= 2'd0;
      addr_q       <= '0;
      rdata        <= '0;
      status       <= '0;
      tmo          <= '0;
      bus.rx_ack_o <= 1'b0;
      bus.tx_stb_o <= 1'b0;
      bus.tx_dat_o <= '0;
      bus.cyc_o    <= 1'b0;
      bus.stb_o    <= 1'b0;
      bus.we_o     <= 1'b0;
      bus.adr_o    <= '0;
      bus.sel_o    <= '0;
      bus.dat_o    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.rx_ack_o <= 1'b1;
          if (rx_fire) begin
            if (bus.rx_dat_i == CMD_WRITE) begin
              is_wr <= 1'b1;
              bcnt  <= 2'd0;
              state <= ADDR;
            end else if (bus.rx_dat_i == CMD_READ) begin
              is_wr <= 1'b0;
              bcnt  <= 2'd0;
              state <= ADDR;
            end
          end
        end

        ADDR: if (rx_fire) begin
          addr_q <= {addr_q[15:0], bus.rx_dat_i};
          bcnt   <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            // Byte-lane bits [1:0] of the last address byte are dropped here.
            bus.adr_o <= {addr_q, bus.rx_dat_i[7:2]};
            if (is_wr) begin
              state <= WDATA;
            end else begin
              state        <= BUS;
              bus.rx_ack_o <= 1'b0;
              bus.cyc_o    <= 1'b1;
              bus.stb_o    <= 1'b1;
              bus.we_o     <= 1'b0;
              bus.sel_o    <= 4'hF;
            end
          end
        end

        WDATA: if (rx_fire) begin
          bus.dat_o <= {bus.dat_o[23:0], bus.rx_dat_i};
          bcnt      <= bcnt + 2'd1;
          if (bcnt == 2'd3) begin
            state        <= BUS;
            bus.rx_ack_o <= 1'b0;
            bus.cyc_o    <= 1'b1;
            bus.stb_o    <= 1'b1;
            bus.we_o     <= 1'b1;
            bus.sel_o    <= 4'hF;
          end
        end

        BUS: begin
          // ack wins on the cycle the counter hits its limit.
          if (bus.ack_i || tmo == TMO_LAST) begin
            state        <= TX_STATUS;
            tmo          <= '0;
            bus.cyc_o    <= 1'b0;
            bus.stb_o    <= 1'b0;
            bus.we_o     <= 1'b0;
            bus.sel_o    <= '0;
            bus.tx_stb_o <= 1'b1;
            if (bus.ack_i) begin
              status       <= ST_OK;
              bus.tx_dat_o <= ST_OK;
              if (!is_wr) rdata <= bus.dat_i;
            end else begin
              status       <= ST_TMO;
              bus.tx_dat_o <= ST_TMO;
              rdata        <= '0;
            end
          end else begin
            tmo <= tmo + 16'd1;
          end
        end

        TX_STATUS: if (tx_fire) begin
          if (!is_wr && status == ST_OK) begin
            state        <= TX_DATA;
            bcnt         <= 2'd0;
            bus.tx_dat_o <= rdata[31:24];
            rdata        <= {rdata[23:0], 8'h00};
          end else begin
            state        <= IDLE;
            bus.tx_stb_o <= 1'b0;
            bus.rx_ack_o <= 1'b1;
          end
        end

        TX_DATA: if (tx_fire) begin
          if (bcnt == 2'd3) begin
            state        <= IDLE;
            bus.tx_stb_o <= 1'b0;
            bus.rx_ack_o <= 1'b1;
          end else begin
            bcnt         <= bcnt + 2'd1;
            bus.tx_dat_o <= rdata[31:24];
            rdata        <= {rdata[23:0], 8'h00};
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/wb_byte_master.md
Name: wb_byte_master

Overview:
- Upstream Wishbone classic master that drives our single-word Wishbone slaves from a byte-stream command channel, such as a UART receiver/transmitter pair or a debug FIFO.
- Parses write and read command frames and issues one 32-bit Wishbone single cycle per frame.
- Returns a status byte, plus read data for reads, on the byte-stream output.
- Sits directly in front of a slave's stb/we/adr/sel/dat/ack port set.

Parameters:
- TIMEOUT, 255: cycles to wait for ack_i before aborting the bus cycle; legal range 1..65535.
- CMD_WRITE, 8'h57: command byte for a write frame ('W').
- CMD_READ, 8'h52: command byte for a read frame ('R').

Ports:
- clk_i  in  1  single system clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- rx_dat_i  in  8  incoming command byte
- rx_stb_i  in  1  rx_dat_i valid
- rx_ack_o  out  1  block ready to accept a byte; a byte transfers when rx_stb_i & rx_ack_o
- tx_dat_o  out  8  outgoing response byte
- tx_stb_o  out  1  tx_dat_o valid
- tx_ack_i  in  1  sink accepts byte; a byte transfers when tx_stb_o & tx_ack_i
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  write enable
- adr_o  out  30  word address [31:2]
- sel_o  out  4  byte selects, always 4'hF during a cycle
- dat_o  out  32  write data
- dat_i  in  32  read data
- ack_i  in  1  slave acknowledge

Behaviour:
- Reset (rst_i sampled high): FSM to IDLE. rx_ack_o, tx_stb_o, cyc_o, stb_o, we_o = 0. adr_o, sel_o, dat_o, tx_dat_o = 0. Timeout counter = 0. Any in-flight frame or bus cycle is dropped without a response. Reset wins over every simultaneous event.
- Frame formats, all multi-byte fields MSB first:
  - Write: CMD_WRITE, A3 A2 A1 A0, D3 D2 D1 D0.
  - Read: CMD_READ, A3 A2 A1 A0.
  - Address bits [1:0] are received but ignored; adr_o = addr[31:2].
- States: IDLE, ADDR, WDATA, BUS, TX_STATUS, TX_DATA.
- IDLE: rx_ack_o=1.
  - Accepted CMD_WRITE: latch we, go to ADDR.
  - Accepted CMD_READ: clear we, go to ADDR.
  - Any other byte: consumed, discarded, stay IDLE, no response.
- ADDR: rx_ack_o=1. Shift in 4 bytes using a 2-bit byte counter. After the 4th byte go to WDATA if write, else BUS.
- WDATA: rx_ack_o=1. Shift in 4 bytes into dat_o, then go to BUS.
- rx_stb_i low: the FSM waits indefinitely. There is no inter-byte timeout.
- BUS:
  - rx_ack_o=0. cyc_o=stb_o=1, sel_o=4'hF, and we_o/adr_o/dat_o stable.
  - cyc/stb rise on the clock edge after the final frame byte is accepted (1-cycle latency).
  - On the edge where ack_i is sampled high: cyc_o=stb_o=we_o=0 next cycle. If read, capture dat_i. Status = 8'h00.
  - Timeout counter increments each BUS cycle with ack_i low. When it reaches TIMEOUT with ack_i still low: drop cyc/stb, status = 8'hEE, read data register = 32'h0.
  - ack_i on the same cycle as reaching TIMEOUT counts as success.
  - Counter clears on leaving BUS.
  - ack_i outside BUS is ignored.
- TX_STATUS: tx_stb_o=1, tx_dat_o=status. Hold both stable until tx_ack_i.
  - Then go to TX_DATA if read and status==8'h00.
  - Otherwise go to IDLE.
- TX_DATA: send read data bytes D3..D0, each held stable until its tx_ack_i, then go to IDLE. tx_stb_o drops the cycle after the last transfer.
- A back-to-back frame may start the cycle after returning to IDLE. rx bytes offered during BUS/TX states are not accepted (rx_ack_o=0).
- Bus cycle count: exactly one Wishbone cycle per complete frame. The block never asserts stb_o without cyc_o.

Test Plan:
- Write ok: rx 57 00 00 00 10 DE AD BE EF, slave acks after 2 cycles.
  - adr_o=30'h4, dat_o=32'hDEADBEEF, we_o=1, sel_o=F, one cycle.
  - tx emits 00 only.
- Read ok: rx 52 00 00 00 13, slave returns 32'h12345678 with ack on first stb cycle.
  - adr_o=30'h4, we_o=0.
  - tx emits 00 12 34 56 78.
- Timeout: TIMEOUT=8, read to address 0x20, no ack.
  - cyc/stb high exactly 8 cycles then low.
  - tx emits EE only.
  - A later ack_i pulse is ignored.
- Back-pressure and junk: leading bytes 41 FF are discarded. Then a read frame runs with tx_ack_i low for 5 cycles on each byte.
  - tx_dat_o holds stable until accepted.
  - Exactly 5 response bytes are sent.
- Reset mid-operation: assert rst_i for 1 cycle while in BUS (cyc_o=1).
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - No status byte is emitted.
  - A following write frame completes normally.
- Stalled input: write frame bytes with 3 idle cycles between each.
  - rx_ack_o stays 1 throughout.
  - Bus cycle starts 1 cycle after the last byte.
